// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: 2-flop synchronizer, majority-voted bits, optional parity, one byte per frame.
// Latency: strobes appear one cycle after edge t + N*P - 1 (t = start detection), +2 cycles from the pin.
// No backpressure: strobes last one cycle and the consumer must capture them on that cycle.
module uart_rx_frame #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      i_CLK,
   input  logic                      i_RST,
   input  logic                      i_RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] i_Prescale,
   input  logic                      i_PAR_EN,
   input  logic                      i_PAR_TYP,
   output logic [DATA_WIDTH-1:0]     o_P_DATA,
   output logic                      o_Data_Valid,
   output logic                      o_PAR_ERR,
   output logic                      o_STP_ERR
);

   localparam int EW = 5;  // holds P-1 up to 31
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                r_state, w_next;
   logic                  r_rx_meta, r_rx_s;
   logic [EW-1:0]         r_edge_cnt, r_pm1;
   logic [BW-1:0]         r_bit_cnt;
   logic                  r_par_en, r_par_typ, r_par_err;
   logic [2:0]            r_smp;
   logic [DATA_WIDTH-1:0] r_shift;

   logic [EW-1:0]         w_cfg_pm1, w_mid;
   logic                  w_start_det, w_last, w_maj, w_data_last;

   // Oversampling ratio decode: anything other than 16 or 32 runs as 8.
   always_comb begin
      w_cfg_pm1 = EW'(7);
      if (i_Prescale == PRESCALE_WIDTH'(16))      w_cfg_pm1 = EW'(15);
      else if (i_Prescale == PRESCALE_WIDTH'(32)) w_cfg_pm1 = EW'(31);
   end

   // Bring the asynchronous line into the clock domain; idle-high reset avoids a false start.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= i_RX_IN;
         r_rx_s    <= r_rx_meta;
      end
   end

   // FSM state register.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // FSM next-state logic: every non-idle state advances on the last oversample of its bit.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (!r_rx_s) w_next = S_START;
         S_START:  if (w_last) w_next = w_maj ? S_IDLE : S_DATA;
         S_DATA:   if (w_last && w_data_last) w_next = r_par_en ? S_PARITY : S_STOP;
         S_PARITY: if (w_last) w_next = S_STOP;
         S_STOP:   if (w_last) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // FSM decode: start detection, end-of-bit, and the 2-of-3 vote around mid-bit.
   always_comb begin
      w_start_det = (r_state == S_IDLE) && !r_rx_s;
      w_last      = (r_state != S_IDLE) && (r_edge_cnt == r_pm1);
      w_data_last = (r_bit_cnt == BW'(DATA_WIDTH - 1));
      w_mid       = r_pm1 >> 1;  // P/2 - 1
      w_maj       = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
   end

   // Bit timing counters; the detection edge itself is oversample 0 of the start bit.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
      end else if (w_start_det) begin
         r_edge_cnt <= EW'(1);
         r_bit_cnt  <= '0;
      end else if (r_state == S_IDLE) begin
         r_edge_cnt <= '0;
      end else if (w_last) begin
         r_edge_cnt <= '0;
         if (r_state == S_DATA) r_bit_cnt <= w_data_last ? '0 : r_bit_cnt + BW'(1);
      end else begin
         r_edge_cnt <= r_edge_cnt + EW'(1);
      end
   end

   // Frame configuration is frozen at start detection so mid-frame changes are ignored.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         r_pm1     <= EW'(7);
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
      end else if (w_start_det) begin
         r_pm1     <= w_cfg_pm1;
         r_par_en  <= i_PAR_EN;
         r_par_typ <= i_PAR_TYP;
      end
   end

   // Capture three mid-bit samples, shift data LSB first, and record the parity verdict.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         r_smp     <= 3'b111;
         r_shift   <= '0;
         r_par_err <= 1'b0;
      end else begin
         if (r_state != S_IDLE) begin
            if (r_edge_cnt == w_mid - EW'(1)) r_smp[0] <= r_rx_s;
            if (r_edge_cnt == w_mid)          r_smp[1] <= r_rx_s;
            if (r_edge_cnt == w_mid + EW'(1)) r_smp[2] <= r_rx_s;
         end
         if (w_start_det) r_par_err <= 1'b0;
         if (w_last && r_state == S_DATA) r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
         if (w_last && r_state == S_PARITY) r_par_err <= w_maj ^ (^r_shift) ^ r_par_typ;
      end
   end

   // Registered outputs: one-cycle strobes at the end of the stop bit; data only on a clean frame.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         o_P_DATA     <= '0;
         o_Data_Valid <= 1'b0;
         o_PAR_ERR    <= 1'b0;
         o_STP_ERR    <= 1'b0;
      end else begin
         o_Data_Valid <= 1'b0;
         o_PAR_ERR    <= 1'b0;
         o_STP_ERR    <= 1'b0;
         if (w_last && r_state == S_STOP) begin
            o_PAR_ERR <= r_par_err;
            o_STP_ERR <= !w_maj;
            if (!r_par_err && w_maj) begin
               o_P_DATA     <= r_shift;
               o_Data_Valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: frame-level reference model predicting each strobe cycle and value.
// Directed scenarios first, then randomized frames with mid-frame configuration scrambling.
module tb_uart_rx_frame;

   logic       i_CLK = 1'b0;
   logic       i_RST = 1'b0;
   logic       i_RX_IN = 1'b1;
   logic [5:0] i_Prescale = 6'd8;
   logic       i_PAR_EN = 1'b0;
   logic       i_PAR_TYP = 1'b0;
   logic [7:0] o_P_DATA;
   logic       o_Data_Valid, o_PAR_ERR, o_STP_ERR;

   uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
      .i_CLK(i_CLK), .i_RST(i_RST), .i_RX_IN(i_RX_IN), .i_Prescale(i_Prescale),
      .i_PAR_EN(i_PAR_EN), .i_PAR_TYP(i_PAR_TYP), .o_P_DATA(o_P_DATA),
      .o_Data_Valid(o_Data_Valid), .o_PAR_ERR(o_PAR_ERR), .o_STP_ERR(o_STP_ERR)
   );

   always #5 i_CLK = ~i_CLK;

   int cyc = 0;
   always @(posedge i_CLK) cyc <= cyc + 1;

   typedef struct {
      int         c;
      bit         v;
      bit         pe;
      bit         se;
      logic [7:0] d;
   } ev_t;

   ev_t        evq[$];
   logic [7:0] mdl_data = 8'h00;
   int         n_chk = 0, n_fail = 0;
   int         n_valid = 0, n_par = 0, n_stp = 0;
   int         vcyc[$];
   int         last_e0 = 0;
   bit         mon_en = 1'b0;
   logic [10:0] exp_o;
   ev_t        cur_ev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle compare against the model; an expected event fires exactly on its predicted cycle.
   always @(negedge i_CLK) begin
      if (mon_en) begin
         if (!i_RST) begin
            check("outputs_in_reset", {21'd0, o_P_DATA, o_Data_Valid, o_PAR_ERR, o_STP_ERR}, 32'd0);
         end else begin
            exp_o = {mdl_data, 3'b000};
            if (evq.size() > 0 && evq[0].c == cyc) begin
               cur_ev = evq.pop_front();
               if (cur_ev.v) mdl_data = cur_ev.d;
               exp_o = {mdl_data, cur_ev.v, cur_ev.pe, cur_ev.se};
            end
            check("outputs", {21'd0, o_P_DATA, o_Data_Valid, o_PAR_ERR, o_STP_ERR}, {21'd0, exp_o});
         end
         if (o_Data_Valid) begin
            n_valid++;
            vcyc.push_back(cyc);
         end
         if (o_PAR_ERR) n_par++;
         if (o_STP_ERR) n_stp++;
      end
   end

   task automatic tick;
      @(posedge i_CLK);
      #1;
   endtask

   function automatic int effp(input logic [5:0] ps);
      return (ps == 6'd16) ? 16 : (ps == 6'd32) ? 32 : 8;
   endfunction

   // Drive one frame; a value driven at frame offset k is the sample the receiver sees at oversample k.
   task automatic send_frame(input logic [7:0] d, input logic [5:0] ps, input bit pe, input bit pt,
                             input bit bad_par, input bit stop_v, input int flip,
                             input int abort_bit, input int gap, input bit scramble);
      int  p, nb;
      bit  bits[11];
      ev_t ev;
      p  = effp(ps);
      nb = pe ? 11 : 10;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
      if (pe) begin
         bits[9]  = (^d) ^ pt ^ bad_par;
         bits[10] = stop_v;
      end else begin
         bits[9]  = stop_v;
         bits[10] = 1'b1;
      end
      i_Prescale = ps;
      i_PAR_EN   = pe;
      i_PAR_TYP  = pt;
      last_e0    = cyc;
      for (int b = 0; b < nb; b++) begin
         for (int j = 0; j < p; j++) begin
            if (abort_bit == b && j == p / 2) begin
               i_RX_IN  = 1'b1;
               mdl_data = 8'h00;
               i_RST    = 1'b0;
               #1;
               check("async_reset_clears", {21'd0, o_P_DATA, o_Data_Valid, o_PAR_ERR, o_STP_ERR}, 32'd0);
               repeat (3) tick;
               i_RST = 1'b1;
               return;
            end
            i_RX_IN = (j == flip) ? ~bits[b] : bits[b];
            if (scramble && b == 1 && j == 0) begin
               i_Prescale = 6'($urandom);
               i_PAR_EN   = 1'($urandom);
               i_PAR_TYP  = 1'($urandom);
            end
            tick;
         end
      end
      ev.c  = last_e0 + 2 + nb * p;
      ev.pe = pe && bad_par;
      ev.se = !stop_v;
      ev.v  = !ev.pe && !ev.se;
      ev.d  = d;
      evq.push_back(ev);
      i_RX_IN = 1'b1;
      repeat (gap) tick;
   endtask

   task automatic wait_drain;
      int k = 0;
      while (evq.size() != 0 && k < 2000) begin
         tick;
         k++;
      end
      check("drain_timeout", evq.size(), 0);
      tick;
   endtask

   initial begin
      int nv0, ps_sel, p, fsel, flip;
      logic [5:0] ps;

      repeat (3) tick;
      mon_en = 1'b1;
      check("reset_state", {21'd0, o_P_DATA, o_Data_Valid, o_PAR_ERR, o_STP_ERR}, 32'd0);
      i_RST = 1'b1;
      repeat (5) tick;

      // Basic byte, P=8, no parity.
      send_frame(8'hAA, 6'd8, 0, 0, 0, 1, -1, -1, 20, 0);
      wait_drain;
      check("basic_valid_count", n_valid, 1);
      if (vcyc.size() > 0) check("basic_latency", vcyc[vcyc.size()-1] - last_e0, 82);
      check("basic_data", o_P_DATA, 8'hAA);

      // Parity good, P=16 even, back-to-back.
      nv0 = vcyc.size();
      send_frame(8'hCC, 6'd16, 1, 0, 0, 1, -1, -1, 0, 0);
      send_frame(8'h05, 6'd16, 1, 0, 0, 1, -1, -1, 10, 0);
      wait_drain;
      check("par_good_count", vcyc.size() - nv0, 2);
      if (vcyc.size() >= nv0 + 2) check("par_good_spacing", vcyc[nv0+1] - vcyc[nv0], 176);
      check("par_good_data", o_P_DATA, 8'h05);
      check("par_good_no_err", n_par + n_stp, 0);

      // Parity bad, P=32 odd.
      send_frame(8'hBB, 6'd32, 1, 1, 1, 1, -1, -1, 10, 0);
      wait_drain;
      check("par_bad_strobe", n_par, 1);
      check("par_bad_no_valid", n_valid, 3);
      check("par_bad_data_kept", o_P_DATA, 8'h05);

      // Stop error, then recovery.
      send_frame(8'hDD, 6'd8, 0, 0, 0, 0, -1, -1, 10, 0);
      wait_drain;
      check("stop_err_strobe", n_stp, 1);
      check("stop_err_no_valid", n_valid, 3);
      send_frame(8'h11, 6'd8, 0, 0, 0, 1, -1, -1, 10, 0);
      wait_drain;
      check("after_stop_data", o_P_DATA, 8'h11);

      // Glitch rejection, then majority vote with a flipped middle sample in every bit.
      i_Prescale = 6'd16;
      i_RX_IN = 1'b0;
      repeat (3) tick;
      i_RX_IN = 1'b1;
      repeat (40) tick;
      check("glitch_no_strobes", n_valid + n_par + n_stp, 6);
      send_frame(8'h3C, 6'd16, 0, 0, 0, 1, 7, -1, 10, 0);
      wait_drain;
      check("majority_data", o_P_DATA, 8'h3C);

      // Reset during data bit 4, then a clean frame.
      send_frame(8'h7E, 6'd8, 0, 0, 0, 1, -1, 5, 0, 0);
      repeat (10) tick;
      send_frame(8'h42, 6'd8, 0, 0, 0, 1, -1, -1, 10, 0);
      wait_drain;
      check("post_reset_data", o_P_DATA, 8'h42);

      // Randomized frames with varied config, errors, sample flips and gaps.
      for (int n = 0; n < 40; n++) begin
         ps_sel = $urandom_range(0, 3);
         ps = (ps_sel == 0) ? 6'd8 : (ps_sel == 1) ? 6'd16 : (ps_sel == 2) ? 6'd32 : 6'($urandom);
         p = effp(ps);
         fsel = $urandom_range(0, 3);
         flip = (fsel == 0) ? -1 : p / 2 - 3 + fsel;
         send_frame(8'($urandom), ps, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) != 0,
                    flip, -1, $urandom_range(0, 4), 1);
      end
      wait_drain;

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Oversampling UART receiver that deserializes one asynchronous serial line into bytes. It produces the parallel byte and single-cycle valid strobe consumed, via the data synchronizer, by the system controller's command decoder. The controller relies on the byte stream `0xAA/0xBB/0xCC/0xDD`, addresses and operands. Runs entirely in the RX clock domain, whose frequency is `Prescale × baud`.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame.
- `PRESCALE_WIDTH`, 6, width of the oversampling-ratio input.

- `i_CLK`  in  1  RX oversampling clock. One clock only.
- `i_RST`  in  1  asynchronous, active-low reset.
- `i_RX_IN`  in  1  serial line. Idles high.
- `i_Prescale`  in  PRESCALE_WIDTH  oversampling ratio P. Legal values are 8, 16 and 32.
- `i_PAR_EN`  in  1  1 = frame carries a parity bit.
- `i_PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `o_P_DATA`  out  DATA_WIDTH  last correctly received byte.
- `o_Data_Valid`  out  1  one-cycle strobe: `o_P_DATA` is new.
- `o_PAR_ERR`  out  1  one-cycle strobe: parity mismatch in the frame just ended.
- `o_STP_ERR`  out  1  one-cycle strobe: stop bit sampled low.

## Operation
- **Input synchronizer.** `i_RX_IN` passes through a 2-flop synchronizer (reset value 1) to produce `rx_s`. All counting below uses `rx_s`.
- **Configuration latch.** `i_Prescale`, `i_PAR_EN` and `i_PAR_TYP` are latched on start detection and held for the whole frame. Changing them mid-frame has no effect.
- **Prescale handling.** Any value other than 16 or 32 is treated as 8.
- **Counters.**
  - `edge_cnt` counts 0..P-1 within each bit.
  - `bit_cnt` counts 0..DATA_WIDTH-1 within DATA.
- **Majority sampling.** `rx_s` is captured at `edge_cnt` = P/2-2, P/2-1 and P/2. The bit value is the 2-of-3 majority. It is evaluated at `edge_cnt` = P-1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when `rx_s` = 0. That clock edge is `edge_cnt` = 0 of the start bit.
  - START at P-1:
    - Majority 1 (glitch) → IDLE. No strobes.
    - Majority 0 → DATA.
  - DATA: shifts bits in LSB first. At P-1 with `bit_cnt` = DATA_WIDTH-1 → PARITY if `i_PAR_EN`, else → STOP.
  - PARITY at P-1: compares the sampled bit with the XOR of the data bits, inverted for odd parity. The result is held in an internal flag. → STOP.
  - STOP at P-1 → IDLE. The registered outputs update on this edge:
    - Parity mismatch: `o_PAR_ERR` = 1.
    - Stop bit sampled 0: `o_STP_ERR` = 1.
    - Both errors may assert together.
    - No errors: `o_P_DATA` ← shift register and `o_Data_Valid` = 1.
    - Any error: `o_Data_Valid` stays 0 and `o_P_DATA` keeps its old value.
- **Back-to-back frames.** IDLE detects a start bit on the cycle immediately after STOP ends, so no idle bits are required between frames.
- **Line held low (break).** Produces a frame with `o_STP_ERR`, then restarts reception immediately.

## Timing
- **Reset values.** `o_P_DATA` = 0, `o_Data_Valid` = `o_PAR_ERR` = `o_STP_ERR` = 0, FSM = IDLE, counters = 0.
- **Reset mid-frame.** Reset asynchronously aborts the frame. No strobe is produced.
- **Frame length.** N = 1 + DATA_WIDTH + `i_PAR_EN` + 1 bits.
- **Strobe timing.** Let t be the edge where IDLE sees `rx_s` = 0. The strobes are high for exactly one cycle following edge t + N·P − 1.
- **Latency from pin.** Measured from the `i_RX_IN` falling edge, add 2 cycles of synchronizer delay.
- **Strobes are never held.** They last one cycle regardless of downstream readiness. The consumer must capture on the strobe cycle.
- **Data stability.** `o_P_DATA` is stable from the valid cycle until the next valid frame.

## Test plan
- **Basic byte.** P=8, parity off, send `0xAA`, idle.
  - `o_Data_Valid` pulses once, 80 cycles after detection (+2 from pin), with `o_P_DATA` = `0xAA`.
- **Parity good.** P=16, even parity, send `0xCC`, then `0x05` back-to-back with correct parity bits.
  - Two valid pulses 176 cycles apart, data `0xCC` then `0x05`, and no error strobes.
- **Parity bad.** P=32, odd parity, send `0xBB` with a wrong parity bit.
  - `o_PAR_ERR` pulses, `o_Data_Valid` stays 0, and `o_P_DATA` keeps the previous byte.
- **Stop error.** P=8, send `0xDD` with the stop bit = 0.
  - `o_STP_ERR` pulses and there is no valid pulse.
  - The line then returns high and sending `0x11` succeeds.
- **Glitch rejection.** P=16, drive a 3-cycle low pulse on an idle line.
  - FSM returns to IDLE after the start bit, with no strobes.
  - Majority check: send `0x3C` with one sample per bit flipped. `0x3C` is still received.
- **Reset mid-frame.** Assert `i_RST` during DATA bit 4 of `0x7E`.
  - All outputs go to 0 immediately.
  - After release, `0x42` is received correctly.
